// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter that serialises single-beat reads and writes onto the SDRAM
// controller native port, with a read-response timeout and a late-beat flush.
module sdram_port_arbiter #(
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [AW-1:0]     r0_addr,
    input  logic [DW-1:0]     r0_wdata,
    input  logic [DW/8-1:0]   r0_be,
    output logic              r0_done,
    output logic [DW-1:0]     r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [AW-1:0]     r1_addr,
    input  logic [DW-1:0]     r1_wdata,
    input  logic [DW/8-1:0]   r1_be,
    output logic              r1_done,
    output logic [DW-1:0]     r1_rdata,
    output logic              r1_err,
    output logic              m_req,
    output logic              m_we,
    output logic [AW-1:0]     m_addr,
    output logic [DW-1:0]     m_wdata,
    output logic [DW/8-1:0]   m_be,
    input  logic              m_ack,
    input  logic              m_rvalid,
    input  logic [DW-1:0]     m_rdata,
    output logic              o_busy,
    output logic [2:0]        fsm_state
);
    // Handshakes: a requester holds req and its fields until its one-cycle done;
    // m_req/m_* stay stable until m_ack is seen; m_rvalid is a single-cycle beat.
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_FLUSH   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          state, state_next;
    logic            grant, last_grant, pick, load;
    logic [CW-1:0]   cnt, cnt_next;
    logic            cap_rd, cap_to, cap_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pick       = 1'b0;
        load       = 1'b0;
        cap_rd     = 1'b0;
        cap_to     = 1'b0;
        cap_wr     = 1'b0;
        case (state)
            S_IDLE: begin
                if (r0_req || r1_req) begin
                    // On a tie, round-robin favours the port that did not win last.
                    if (r0_req && r1_req) pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
                    else                  pick = r1_req;
                    load       = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_ack) begin
                    if (m_we) begin
                        cap_wr     = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        cnt_next   = '0;
                        state_next = S_WAIT_RD;
                    end
                end
            end
            S_WAIT_RD: begin
                if (m_rvalid) begin
                    cap_rd     = 1'b1;
                    state_next = S_DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    cnt_next   = '0;
                    state_next = S_FLUSH;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_FLUSH: begin
                // Swallow the one late beat so it cannot complete a later read.
                if (m_rvalid || cnt == CW'(TIMEOUT - 1)) begin
                    cap_to     = 1'b1;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_be       <= '0;
            r0_rdata   <= '0;
            r0_err     <= 1'b0;
            r1_rdata   <= '0;
            r1_err     <= 1'b0;
        end else begin
            if (load) begin
                grant      <= pick;
                last_grant <= pick;
                m_we       <= pick ? r1_we    : r0_we;
                m_addr     <= pick ? r1_addr  : r0_addr;
                m_wdata    <= pick ? r1_wdata : r0_wdata;
                m_be       <= pick ? r1_be    : r0_be;
            end
            if (cap_rd || cap_to || cap_wr) begin
                if (grant) begin
                    r1_err <= cap_to;
                    if (!cap_wr) r1_rdata <= cap_rd ? m_rdata : '0;
                end else begin
                    r0_err <= cap_to;
                    if (!cap_wr) r0_rdata <= cap_rd ? m_rdata : '0;
                end
            end
        end
    end

    assign m_req     = (state == S_ISSUE);
    assign r0_done   = (state == S_DONE) && !grant;
    assign r1_done   = (state == S_DONE) && grant;
    assign o_busy    = (state != S_IDLE);
    assign fsm_state = state;

endmodule
